// File: rtl/divider_param_if.sv
// Start/ready handshake and operand/result bus of the iterative divider.
// The master drives request and operands; the divider is the slave.
interface divider_param_if #(
   parameter int WIDTH = 9
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] Abus;
   logic [WIDTH-1:0] Bbus;
   logic [WIDTH-1:0] Qbus;
   logic [WIDTH-1:0] Rbus;
   logic             ready;
   logic             busy;
   logic             dbz;
   logic             ovf;

   modport master (
      output start, signed_mode, Abus, Bbus,
      input  Qbus, Rbus, ready, busy, dbz, ovf
   );

   modport slave (
      input  start, signed_mode, Abus, Bbus,
      output Qbus, Rbus, ready, busy, dbz, ovf
   );
endinterface

// File: rtl/divider_param.sv
// Restoring shift-subtract divider, one quotient bit per clock, with signed mode,
// divide-by-zero and signed-overflow short paths resolved in a single FIX cycle.
module divider_param #(
   parameter int WIDTH = 9
) (
   input  logic           clk,
   input  logic           rst,
   divider_param_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_is_dbz;
   logic             r_is_ovf;
   logic             r_ready;
   logic             r_busy;
   logic             r_dbz;
   logic             r_ovf;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_b_zero;
   logic             w_ovf;
   logic [WIDTH:0]   w_part;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_rem_nx;

   function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      logic signed [WIDTH-1:0] s;
      s = $signed(v);
      return neg ? $unsigned(-s) : v;
   endfunction

   // Operand decode: magnitudes fit in WIDTH bits, including the most negative value
   assign w_a_neg  = bus.signed_mode & bus.Abus[WIDTH-1];
   assign w_b_neg  = bus.signed_mode & bus.Bbus[WIDTH-1];
   assign w_a_mag  = f_cond_neg(bus.Abus, w_a_neg);
   assign w_b_mag  = f_cond_neg(bus.Bbus, w_b_neg);
   assign w_b_zero = (bus.Bbus == '0);
   assign w_ovf    = bus.signed_mode && (bus.Abus == {1'b1, {(WIDTH-1){1'b0}}})
                     && (bus.Bbus == '1);

   // Partial remainder needs one extra bit since rem < div may reach 2^WIDTH-2
   assign w_part   = {r_rem, r_quo[WIDTH-1]};
   assign w_ge     = (w_part >= {1'b0, r_div});
   assign w_diff   = w_part[WIDTH-1:0] - r_div;
   assign w_rem_nx = w_ge ? w_diff : w_part[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_a      <= '0;
         r_q      <= '0;
         r_r      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_dbz <= 1'b0;
         r_is_ovf <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_a      <= bus.Abus;
                  r_div    <= w_b_mag;
                  r_quo    <= w_a_mag;
                  r_rem    <= '0;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_is_dbz <= w_b_zero;
                  r_is_ovf <= w_ovf;
                  r_cnt    <= CW'(WIDTH);
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_dbz    <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_state  <= (w_b_zero || w_ovf) ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nx;
               r_quo <= {r_quo[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_is_dbz) begin
                  r_q   <= '1;
                  r_r   <= r_a;
                  r_dbz <= 1'b1;
               end else if (r_is_ovf) begin
                  r_q   <= r_a;
                  r_r   <= '0;
                  r_ovf <= 1'b1;
               end else begin
                  r_q <= f_cond_neg(r_quo, r_neg_q);
                  r_r <= f_cond_neg(r_rem, r_neg_r);
               end
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.Qbus  = r_q;
   assign bus.Rbus  = r_r;
   assign bus.ready = r_ready;
   assign bus.busy  = r_busy;
   assign bus.dbz   = r_dbz;
   assign bus.ovf   = r_ovf;
endmodule
